// File: rtl/joybus_tx.sv
// joybus_tx
//   Console-side Joybus command transmitter. Shifts out up to 24 command
//   bits MSB-first as pulse-width encoded cells on the open-drain bus, then
//   appends the console stop bit. When the frame ends it pulses rx_start,
//   which arms the companion receiver before the controller begins to reply.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   tx_start  in   single-cycle request, sampled only while idle
//   tx_data   in   [23:0] command bits, left-aligned (bit 23 sent first)
//   tx_len    in   [4:0] number of data bits, 0..24 (larger values clamp to 24)
//   JB_TX     out  line drive: 0 pulls the bus low, 1 releases it
//   tx_busy   out  high from the accepted start until the frame ends
//   tx_done   out  one-cycle pulse when the frame ends
//   rx_start  out  one-cycle pulse coincident with tx_done
module joybus_tx #(
    parameter int CYC_PER_US = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [23:0] tx_data,
    input  logic [4:0]  tx_len,
    output logic        JB_TX,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        rx_start
);

    localparam int T1   = CYC_PER_US;
    localparam int T3   = 3 * CYC_PER_US;
    localparam int CELL = 4 * CYC_PER_US;
    localparam int CW   = $clog2(CELL);

    localparam logic [CW-1:0] T1_M1 = CW'(T1 - 1);
    localparam logic [CW-1:0] T3_M1 = CW'(T3 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_STOP_LOW
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_bits;
    logic [23:0]     r_shift;
    logic            r_jb_tx;
    logic            r_busy;
    logic            r_done;
    logic            r_rx_start;

    logic [4:0]      w_len;
    logic [CW-1:0]   w_low_m1;
    logic [CW-1:0]   w_high_m1;

    assign w_len = (tx_len > 5'd24) ? 5'd24 : tx_len;

    // The bit being sent stays at r_shift[23] through both of its phases; the
    // shift only happens at the end of the high phase.
    assign w_low_m1  = r_shift[23] ? T1_M1 : T3_M1;
    assign w_high_m1 = r_shift[23] ? T3_M1 : T1_M1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bits     <= '0;
            r_shift    <= '0;
            r_jb_tx    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rx_start <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_jb_tx <= 1'b1;
                    if (tx_start) begin
                        // Line goes low on the accepting edge so the first low
                        // cycle is the very next one.
                        r_shift <= tx_data;
                        r_bits  <= w_len;
                        r_cnt   <= '0;
                        r_jb_tx <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= (w_len != 5'd0) ? S_LOW : S_STOP_LOW;
                    end
                end
                S_LOW: begin
                    if (r_cnt == w_low_m1) begin
                        r_cnt   <= '0;
                        r_jb_tx <= 1'b1;
                        r_state <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (r_cnt == w_high_m1) begin
                        r_cnt   <= '0;
                        r_shift <= {r_shift[22:0], 1'b0};
                        r_bits  <= r_bits - 1'b1;
                        r_jb_tx <= 1'b0;
                        r_state <= (r_bits == 5'd1) ? S_STOP_LOW : S_LOW;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP_LOW: begin
                    if (r_cnt == T1_M1) begin
                        r_cnt      <= '0;
                        r_jb_tx    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_rx_start <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_jb_tx <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign JB_TX    = r_jb_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;
    assign rx_start = r_rx_start;

endmodule
